// File: rtl/accu_program_sequencer.sv
// accu_program_sequencer
// Fetch/decode/execute controller for one accumulator+ALU unit. It fetches
// instruction words {class, op, operand} over a req/valid handshake, presents
// opcode/operand and the accumulator clock-enable to the datapath, and
// resolves unconditional and carry-conditional jumps.
//
// Optional feature macro: SEQ_SINGLE_STEP_EN
//   When defined, an extra input `step` gates completion of every EXEC cycle
//   so the program can be advanced one instruction at a time.
//
// Datapath widths default to the DATA_WIDTH / OP_CODE_WIDTH macros shared
// with the accumulator+ALU unit, falling back to 8 and 4.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef OP_CODE_WIDTH
`define OP_CODE_WIDTH 4
`endif

module accu_program_sequencer #(
    parameter int data_width    = `DATA_WIDTH,
    parameter int op_code_width = `OP_CODE_WIDTH,
    parameter int pc_width      = 6,
    parameter int instr_width   = 2 + op_code_width + data_width
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                     step,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     imem_req,
    output logic [pc_width-1:0]      imem_addr,
    input  logic                     imem_valid,
    input  logic [instr_width-1:0]   imem_data,
    output logic [op_code_width-1:0] opcode,
    output logic [data_width-1:0]    operand,
    output logic                     acc_ce,
    output logic                     acc_clr,
    input  logic                     cy,
    output logic [pc_width-1:0]      pc_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_JMP  = 2'b01;
    localparam logic [1:0] CLS_JC   = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    // Instruction field extraction.
    function automatic logic [1:0] instr_class(input logic [instr_width-1:0] w);
        return w[instr_width-1 -: 2];
    endfunction

    function automatic logic [op_code_width-1:0] instr_op(input logic [instr_width-1:0] w);
        return w[data_width +: op_code_width];
    endfunction

    function automatic logic [data_width-1:0] instr_operand(input logic [instr_width-1:0] w);
        return w[data_width-1:0];
    endfunction

    // Jump target: operand bits above the program counter width are dropped.
    function automatic logic [pc_width-1:0] jump_target(input logic [instr_width-1:0] w);
        return w[pc_width-1:0];
    endfunction

    state_t                   state_r;
    logic [pc_width-1:0]      pc_r;
    logic [instr_width-1:0]   ir_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     imem_req_r;
    logic                     acc_ce_r;
    logic                     acc_clr_r;
    logic                     exec_go_s;
    logic [pc_width-1:0]      pc_inc_s;

    // Sequential pc increment; wraps silently at the top of program space.
    assign pc_inc_s = pc_r + pc_width'(1);

`ifdef SEQ_SINGLE_STEP_EN
    // EXEC only completes in a cycle where step is high; acc_ce is gated so
    // the accumulator only loads in that completing cycle.
    assign exec_go_s = step;
    assign acc_ce    = acc_ce_r & step;
`else
    // EXEC always completes in a single cycle.
    assign exec_go_s = 1'b1;
    assign acc_ce    = acc_ce_r;
`endif

    assign busy      = busy_r;
    assign done      = done_r;
    assign imem_req  = imem_req_r;
    assign imem_addr = pc_r;
    assign pc_o      = pc_r;
    assign acc_clr   = acc_clr_r;
    // opcode/operand come straight from the instruction register, so they stay
    // stable from EXEC entry until the next instruction is latched.
    assign opcode    = instr_op(ir_r);
    assign operand   = instr_operand(ir_r);

    // Control FSM with all control outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pc_r       <= '0;
            ir_r       <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            imem_req_r <= 1'b0;
            acc_ce_r   <= 1'b0;
            acc_clr_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r   <= 1'b0;
                    acc_ce_r <= 1'b0;
                    if (start) begin
                        // Clear the accumulator during the first fetch cycle.
                        state_r    <= ST_FETCH;
                        pc_r       <= '0;
                        busy_r     <= 1'b1;
                        imem_req_r <= 1'b1;
                        acc_clr_r  <= 1'b1;
                    end else begin
                        busy_r     <= 1'b0;
                        imem_req_r <= 1'b0;
                        acc_clr_r  <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    acc_clr_r <= 1'b0;
                    if (imem_valid) begin
                        ir_r       <= imem_data;
                        imem_req_r <= 1'b0;
                        acc_ce_r   <= (instr_class(imem_data) == CLS_ALU);
                        state_r    <= ST_EXEC;
                    end else begin
                        // Unbounded wait: keep the request and address steady.
                        imem_req_r <= 1'b1;
                        acc_ce_r   <= 1'b0;
                    end
                end

                ST_EXEC: begin
                    if (exec_go_s) begin
                        acc_ce_r <= 1'b0;
                        case (instr_class(ir_r))
                            CLS_ALU: begin
                                pc_r       <= pc_inc_s;
                                imem_req_r <= 1'b1;
                                state_r    <= ST_FETCH;
                            end
                            CLS_JMP: begin
                                pc_r       <= jump_target(ir_r);
                                imem_req_r <= 1'b1;
                                state_r    <= ST_FETCH;
                            end
                            CLS_JC: begin
                                // cy holds the carry registered by the last ALU op.
                                pc_r       <= cy ? jump_target(ir_r) : pc_inc_s;
                                imem_req_r <= 1'b1;
                                state_r    <= ST_FETCH;
                            end
                            CLS_HALT: begin
                                done_r     <= 1'b1;
                                imem_req_r <= 1'b0;
                                state_r    <= ST_DONE;
                            end
                            default: begin
                                imem_req_r <= 1'b0;
                                state_r    <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        // Single-step hold: everything stays as latched.
                        state_r <= ST_EXEC;
                    end
                end

                ST_DONE: begin
                    // pc is left pointing at the HALT instruction.
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    imem_req_r <= 1'b0;
                    acc_ce_r   <= 1'b0;
                    acc_clr_r  <= 1'b0;
                    state_r    <= ST_IDLE;
                end

                default: begin
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    imem_req_r <= 1'b0;
                    acc_ce_r   <= 1'b0;
                    acc_clr_r  <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accu_program_sequencer.sv
// Self-checking bench for accu_program_sequencer.
// An instruction-level interpreter builds the expected per-cycle output trace
// of each program; a single compare process checks the DUT against it every
// cycle, and literal expectations pin fetch-address order, acc_ce contents and
// done timing. A tiny accumulator stand-in produces cy (carry=1 after an ALU
// op with opcode 4'hF, 0 otherwise). Optional SEQ_SINGLE_STEP_EN is covered
// when that macro is defined.

module tb_accu_program_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, imem_req, imem_valid, acc_ce, acc_clr;
    logic        cy;
    logic [5:0]  imem_addr, pc_o;
    logic [13:0] imem_data;
    logic [3:0]  opcode;
    logic [7:0]  operand;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step;
`endif

    logic [13:0] rom [64];
    int          waits;
    int          wcnt;
    logic        force_valid;

    int          checks   = 0;
    int          failures = 0;

    logic [28:0] expq [$];
    logic        armed = 1'b0;
    int          cyc;
    int          done_idx;
    logic        prev_req;
    int          fa_log [$];
    int          ce_log [$];

    accu_program_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef SEQ_SINGLE_STEP_EN
        .step       (step),
`endif
        .busy       (busy),
        .done       (done),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .opcode     (opcode),
        .operand    (operand),
        .acc_ce     (acc_ce),
        .acc_clr    (acc_clr),
        .cy         (cy),
        .pc_o       (pc_o)
    );

    always #5 clk = ~clk;

    // Program memory with a configurable number of wait cycles per fetch.
    assign imem_data  = rom[imem_addr];
    assign imem_valid = (imem_req && (wcnt == waits)) || force_valid;

    always @(posedge clk) begin
        if (imem_req && !imem_valid) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
    end

    // Accumulator stand-in: registered carry.
    always @(posedge clk) begin
        if (rst || acc_clr) cy <= 1'b0;
        else if (acc_ce)    cy <= (opcode == 4'hF);
    end

    function automatic logic [13:0] mk(input logic [1:0] c, input logic [3:0] op, input logic [7:0] d);
        return {c, op, d};
    endfunction

    function automatic logic [28:0] mkexp(input logic b, input logic dn, input logic rq,
                                          input logic [5:0] pc, input logic ce, input logic clr,
                                          input logic [13:0] ins);
        return {b, dn, rq, pc, pc, ce, clr, ins[11:8], ins[7:0]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_list(input string name, input int got[$], input int want[$]);
        chk({name, "_len"}, got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++)
            chk(name, got[i], want[i]);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = mk(2'b11, 4'h0, 8'h00);
    endtask

    // Instruction-level interpreter: expands the program into expected cycles.
    task automatic build_trace(input int w);
        logic [5:0]  pc;
        logic [13:0] ins, last;
        logic        c, halted;
        pc = 6'd0; last = 14'd0; c = 1'b0; halted = 1'b0;
        expq.delete();
        for (int n = 0; n < 200 && !halted; n++) begin
            ins = rom[pc];
            for (int k = 0; k <= w; k++)
                expq.push_back(mkexp(1'b1, 1'b0, 1'b1, pc, 1'b0, (n == 0 && k == 0), last));
            last = ins;
            expq.push_back(mkexp(1'b1, 1'b0, 1'b0, pc, (ins[13:12] == 2'b00), 1'b0, last));
            case (ins[13:12])
                2'b00: begin c = (ins[11:8] == 4'hF); pc = pc + 6'd1; end
                2'b01: pc = ins[5:0];
                2'b10: pc = c ? ins[5:0] : pc + 6'd1;
                default: begin
                    expq.push_back(mkexp(1'b1, 1'b1, 1'b0, pc, 1'b0, 1'b0, last));
                    expq.push_back(mkexp(1'b0, 1'b0, 1'b0, pc, 1'b0, 1'b0, last));
                    halted = 1'b1;
                end
            endcase
        end
    endtask

    // Per-cycle compare against the interpreter trace, plus event logs.
    always @(negedge clk) begin
        logic [28:0] a, e;
        if (armed && expq.size() > 0) begin
            e = expq.pop_front();
            a = {busy, done, imem_req, imem_addr, pc_o, acc_ce, acc_clr, opcode, operand};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle%0d actual=%h expected=%h", cyc, a, e);
            end
            if (done) done_idx = cyc;
            if (acc_ce) ce_log.push_back(int'({opcode, operand}));
            if (imem_req && !prev_req) fa_log.push_back(int'(imem_addr));
            prev_req = imem_req;
            cyc++;
        end
    end

    task automatic run_prog(input int w);
        waits = w;
        build_trace(w);
        fa_log.delete(); ce_log.delete();
        cyc = 0; done_idx = -1; prev_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0; start = 1'b1;
        @(posedge clk);
        armed = 1'b1;
        #1 start = 1'b0;
        for (int i = 0; i < 3000 && expq.size() > 0; i++) @(negedge clk);
        chk("trace_timeout", expq.size(), 0);
        armed = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; force_valid = 1'b0; waits = 100;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b1;
`endif
        clear_rom();

        // Reset with start held high.
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_ce", acc_ce, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_done", done, 0);
        chk("rst_opcode", opcode, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_clr", acc_clr, 1);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        start = 1'b0;
        @(negedge clk);
        chk("clr_one_cycle", acc_clr, 0);
        chk("wait_req_held", imem_req, 1);

        // Reset during a fetch wait, then a late valid must be ignored.
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_req", imem_req, 0);
        rst = 1'b0; force_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        force_valid = 1'b0;
        chk("late_valid_busy", busy, 0);
        chk("late_valid_ce", acc_ce, 0);
        chk("late_valid_pc", pc_o, 0);

        // Straight-line program, zero wait.
        clear_rom();
        rom[0] = mk(2'b00, 4'h1, 8'h05);
        rom[1] = mk(2'b00, 4'h2, 8'h03);
        rom[2] = mk(2'b11, 4'h0, 8'h00);
        run_prog(0);
        chk_list("sl_ce", ce_log, '{32'h105, 32'h203});
        chk("sl_done_idx", done_idx, 6);
        chk_list("sl_fetch", fa_log, '{0, 1, 2});

        // Same program with three wait cycles per fetch.
        run_prog(3);
        chk_list("ws_ce", ce_log, '{32'h105, 32'h203});
        chk("ws_done_idx", done_idx, 15);

        // Conditional jump taken (carry set by opcode F).
        clear_rom();
        rom[0] = mk(2'b00, 4'hF, 8'h00);
        rom[1] = mk(2'b10, 4'h0, 8'h10);
        run_prog(0);
        chk_list("jc_taken", fa_log, '{0, 1, 16});

        // Conditional jump not taken.
        rom[0] = mk(2'b00, 4'h1, 8'h00);
        run_prog(1);
        chk_list("jc_not_taken", fa_log, '{0, 1, 2});

        // Jump masking and pc wrap: 0 JC(not taken) -> 1 JMP FF -> 3F ALU F -> 0 JC taken -> 5 HALT.
        clear_rom();
        rom[0]  = mk(2'b10, 4'h0, 8'h05);
        rom[1]  = mk(2'b01, 4'h0, 8'hFF);
        rom[63] = mk(2'b00, 4'hF, 8'h00);
        run_prog(0);
        chk_list("wrap_fetch", fa_log, '{0, 1, 63, 0, 5});

`ifdef SEQ_SINGLE_STEP_EN
        // Step gating: EXEC holds with acc_ce low until the step pulse.
        clear_rom();
        rom[0] = mk(2'b00, 4'h1, 8'h05);
        waits = 0; step = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0; start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("step_hold_ce", acc_ce, 0);
            chk("step_hold_pc", pc_o, 0);
            chk("step_hold_op", opcode, 1);
        end
        step = 1'b1;
        #1 chk("step_ce", acc_ce, 1);
        @(negedge clk) step = 1'b0;
        #1;
        chk("step_after_ce", acc_ce, 0);
        chk("step_after_pc", pc_o, 1);
        chk("step_after_req", imem_req, 1);
        step = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
